// File: rtl/con_pkg.sv
`default_nettype none
// ============================================================================
// Module      : con_pkg
// Description : Shared types for the console area responder: FSM state
//               encoding and error-code values reported on om_err_code.
// Revision    : 1.0 - initial release
// ============================================================================
package con_pkg;

    // Responder FSM states, explicitly encoded in 4 bits
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CHECK = 4'd1,
        ST_RD    = 4'd2,
        ST_WAIT  = 4'd3,
        ST_SEND  = 4'd4,
        ST_CSUM  = 4'd5,
        ST_DONE  = 4'd6,
        ST_ERR   = 4'd7
    } con_state_t;

    // Error codes reported on om_err_code
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_RANGE   = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage
`default_nettype wire

// File: rtl/con_stall_timer.sv
`default_nettype none
// ============================================================================
// Module      : con_stall_timer
// Description : Counts consecutive stalled TX cycles. o_tc is raised in the
//               cycle that would be the TIMEOUT-th consecutive stall, so the
//               owner can abort on that same clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module con_stall_timer #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    // Stall counter: cleared on request, saturates at the terminal count
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_tc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Terminal count: this stalled cycle is the TIMEOUT-th in a row
    assign o_tc = i_enable && (r_cnt == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/con_area_resp.sv
`default_nettype none
// ============================================================================
// Module      : con_area_resp
// Description : Console area responder. On a start pulse it range-checks the
//               absolute address, reads BURST_LEN words from local RAM,
//               streams them plus a running checksum over a valid/ready port,
//               then pulses o_done (or o_error on range/overrun/timeout).
//               All outputs are registered from the next-state decode.
// Revision    : 1.0 - initial release
// ============================================================================
module con_area_resp
    import con_pkg::*;
#(
    parameter int AREA_BASE = 128,
    parameter int AREA_LEN  = 272,
    parameter int BURST_LEN = 8,
    parameter int DATA_W    = 16,
    parameter int TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [9:0]        im_base_addr,
    output logic              o_done,
    output logic              o_error,
    output logic [1:0]        om_err_code,
    output logic [9:0]        om_ram_addr,
    output logic              o_ram_rd,
    input  logic [DATA_W-1:0] im_ram_rdata,
    output logic              o_tx_valid,
    output logic [DATA_W-1:0] om_tx_data,
    input  logic              i_tx_ready
);

    localparam int         IDX_W   = $clog2(BURST_LEN + 1);
    // 11-bit bounds so the range and overrun checks cannot wrap
    localparam logic [10:0] c_lo    = 11'(AREA_BASE);
    localparam logic [10:0] c_hi    = 11'(AREA_BASE + AREA_LEN);
    localparam logic [10:0] c_len   = 11'(AREA_LEN);
    localparam logic [10:0] c_burst = 11'(BURST_LEN);

    con_state_t        r_state, w_state_nxt;
    logic [9:0]        r_addr, w_addr_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic [DATA_W-1:0] r_csum, w_csum_nxt;
    logic [DATA_W-1:0] r_tx_data, w_word_nxt;
    logic [1:0]        r_err_code, w_err_code_nxt;
    logic [9:0]        r_ram_addr;
    logic              r_ram_rd, r_tx_valid, r_done, r_error;

    logic [9:0]        w_offset;
    logic              w_in_range, w_overrun;
    logic              w_beat, w_stall, w_timer_clr, w_timeout;
    logic              w_tx_nxt;

    assign w_offset   = r_addr - 10'(AREA_BASE);
    assign w_in_range = ({1'b0, r_addr} >= c_lo) && ({1'b0, r_addr} < c_hi);
    assign w_overrun  = ({1'b0, w_offset} + c_burst) > c_len;

    assign w_beat      = r_tx_valid & i_tx_ready;
    assign w_stall     = r_tx_valid & ~i_tx_ready;
    assign w_timer_clr = ~((r_state == ST_SEND) || (r_state == ST_CSUM)) | w_beat;

    con_stall_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_stall_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_timer_clr),
        .i_enable (w_stall),
        .o_tc     (w_timeout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath next-value decode
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_idx_nxt      = r_idx;
        w_csum_nxt     = r_csum;
        w_err_code_nxt = r_err_code;
        w_word_nxt     = r_tx_data;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_addr_nxt     = im_base_addr;
                    w_err_code_nxt = ERR_NONE;
                    w_idx_nxt      = '0;
                    w_csum_nxt     = '0;
                    w_state_nxt    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!w_in_range) begin
                    w_err_code_nxt = ERR_RANGE;
                    w_state_nxt    = ST_ERR;
                end else if (w_overrun) begin
                    w_err_code_nxt = ERR_OVERRUN;
                    w_state_nxt    = ST_ERR;
                end else begin
                    w_state_nxt    = ST_RD;
                end
            end
            ST_RD: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_word_nxt  = im_ram_rdata;
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (w_beat) begin
                    w_csum_nxt = r_csum + r_tx_data;
                    w_idx_nxt  = r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(BURST_LEN - 1)) begin
                        w_word_nxt  = w_csum_nxt;
                        w_state_nxt = ST_CSUM;
                    end else begin
                        w_state_nxt = ST_RD;
                    end
                end else if (w_timeout) begin
                    w_err_code_nxt = ERR_TIMEOUT;
                    w_state_nxt    = ST_ERR;
                end
            end
            ST_CSUM: begin
                if (w_beat) begin
                    w_state_nxt = ST_DONE;
                end else if (w_timeout) begin
                    w_err_code_nxt = ERR_TIMEOUT;
                    w_state_nxt    = ST_ERR;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_tx_nxt = (w_state_nxt == ST_SEND) || (w_state_nxt == ST_CSUM);

    // Datapath and output registers, decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_idx      <= '0;
            r_csum     <= '0;
            r_err_code <= ERR_NONE;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_ram_rd   <= 1'b0;
            r_ram_addr <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_addr     <= w_addr_nxt;
            r_idx      <= w_idx_nxt;
            r_csum     <= w_csum_nxt;
            r_err_code <= w_err_code_nxt;
            r_tx_valid <= w_tx_nxt;
            r_tx_data  <= w_tx_nxt ? w_word_nxt : '0;
            r_ram_rd   <= (w_state_nxt == ST_RD);
            r_ram_addr <= (w_state_nxt == ST_RD) ? (w_offset + 10'(w_idx_nxt)) : '0;
            r_done     <= (w_state_nxt == ST_DONE);
            r_error    <= (w_state_nxt == ST_ERR);
        end
    end

    assign o_done      = r_done;
    assign o_error     = r_error;
    assign om_err_code = r_err_code;
    assign om_ram_addr = r_ram_addr;
    assign o_ram_rd    = r_ram_rd;
    assign o_tx_valid  = r_tx_valid;
    assign om_tx_data  = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_con_area_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_con_area_resp
// Description : Self-checking bench for con_area_resp. A behavioural model
//               derives the expected error code, RAM read addresses and TX
//               word stream per access from the area rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_con_area_resp;

    localparam int AREA_BASE = 128;
    localparam int AREA_LEN  = 272;
    localparam int BURST_LEN = 8;
    localparam int TIMEOUT   = 1023;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [9:0]  im_base_addr;
    logic        o_done, o_error;
    logic [1:0]  om_err_code;
    logic [9:0]  om_ram_addr;
    logic        o_ram_rd;
    logic [15:0] im_ram_rdata;
    logic        o_tx_valid;
    logic [15:0] om_tx_data;
    logic        i_tx_ready;

    logic [15:0] ram [0:AREA_LEN-1];
    logic [15:0] ram_q = '0;

    int total = 0;
    int bad   = 0;

    // observation state
    int cyc = 0, c0 = 0, mode = 0;
    int beats[$], beat_cyc[$], rd_addr[$];
    int done_hi, err_hi, done_at, err_at, first_valid, ram_addr_nz, stab_viol;
    logic valid_at_err;
    logic prev_valid = 1'b0, prev_ready = 1'b0;
    logic [15:0] prev_data = '0;

    // expectation state
    int exp_code;
    int exp_beats[$], exp_rd[$];

    con_area_resp #(
        .AREA_BASE (AREA_BASE),
        .AREA_LEN  (AREA_LEN),
        .BURST_LEN (BURST_LEN),
        .DATA_W    (16),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .im_base_addr (im_base_addr),
        .o_done       (o_done),
        .o_error      (o_error),
        .om_err_code  (om_err_code),
        .om_ram_addr  (om_ram_addr),
        .o_ram_rd     (o_ram_rd),
        .im_ram_rdata (im_ram_rdata),
        .o_tx_valid   (o_tx_valid),
        .om_tx_data   (om_tx_data),
        .i_tx_ready   (i_tx_ready)
    );

    always #5 clk = ~clk;

    // Local RAM with one-cycle read latency
    always @(posedge clk) begin
        if (o_ram_rd && om_ram_addr < 10'(AREA_LEN)) ram_q <= ram[om_ram_addr];
    end
    assign im_ram_rdata = ram_q;

    task automatic chk(input string tag, input int obs, input int exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Advance one clock, observe outputs, then choose ready for the next edge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        i_start = 1'b0;
        if (o_ram_rd) rd_addr.push_back(int'(om_ram_addr));
        if (om_ram_addr != '0) ram_addr_nz++;
        if (o_done) begin done_hi++; done_at = cyc; end
        if (o_error) begin err_hi++; err_at = cyc; valid_at_err = o_tx_valid; end
        if (prev_valid && !prev_ready && o_tx_valid && om_tx_data !== prev_data) stab_viol++;
        if (o_tx_valid && first_valid < 0) first_valid = cyc;
        case (mode)
            1:       i_tx_ready = 1'($urandom_range(0, 1));
            2:       i_tx_ready = (first_valid < 0);
            3:       i_tx_ready = (first_valid < 0) || (cyc - first_valid >= TIMEOUT - 1);
            default: i_tx_ready = 1'b1;
        endcase
        if (o_tx_valid && i_tx_ready) begin
            beats.push_back(int'(om_tx_data));
            beat_cyc.push_back(cyc);
        end
        prev_valid = o_tx_valid;
        prev_ready = i_tx_ready;
        prev_data  = om_tx_data;
    endtask

    task automatic begin_access(input int addr, input int m);
        beats.delete(); beat_cyc.delete(); rd_addr.delete();
        done_hi = 0; err_hi = 0; done_at = -1; err_at = -1;
        first_valid = -1; ram_addr_nz = 0; stab_viol = 0; valid_at_err = 1'b0;
        mode = m;
        c0 = cyc;
        i_start = 1'b1;
        im_base_addr = 10'(addr);
    endtask

    task automatic finish_access(input int budget);
        while (done_hi == 0 && err_hi == 0 && cyc - c0 < budget) step();
        repeat (3) step();
    endtask

    // Reference: what an access at absolute address addr must produce
    task automatic model(input int addr);
        int off, sum;
        exp_beats.delete(); exp_rd.delete();
        off = addr - AREA_BASE;
        if (addr < AREA_BASE || addr >= AREA_BASE + AREA_LEN) exp_code = 1;
        else if (off + BURST_LEN > AREA_LEN) exp_code = 2;
        else begin
            exp_code = 0;
            sum = 0;
            for (int k = 0; k < BURST_LEN; k++) begin
                exp_rd.push_back(off + k);
                exp_beats.push_back(int'(ram[off + k]));
                sum = (sum + int'(ram[off + k])) % 65536;
            end
            exp_beats.push_back(sum);
        end
    endtask

    task automatic check_access(input string tag);
        int nb, nr;
        chk({tag, ".done"}, done_hi, (exp_code == 0) ? 1 : 0);
        chk({tag, ".error"}, err_hi, (exp_code != 0) ? 1 : 0);
        chk({tag, ".code"}, int'(om_err_code), exp_code);
        chk({tag, ".nbeats"}, beats.size(), exp_beats.size());
        nb = 0;
        for (int i = 0; i < beats.size() && i < exp_beats.size(); i++)
            if (beats[i] != exp_beats[i]) nb++;
        chk({tag, ".beat_data_mismatches"}, nb, 0);
        chk({tag, ".nreads"}, rd_addr.size(), exp_rd.size());
        nr = 0;
        for (int i = 0; i < rd_addr.size() && i < exp_rd.size(); i++)
            if (rd_addr[i] != exp_rd[i]) nr++;
        chk({tag, ".read_addr_mismatches"}, nr, 0);
        chk({tag, ".hold_violations"}, stab_viol, 0);
        if (exp_code != 0) chk({tag, ".ram_addr_nonzero"}, ram_addr_nz, 0);
    endtask

    initial begin
        int gaps, a, r;
        rst = 1'b1; i_start = 1'b0; im_base_addr = '0; i_tx_ready = 1'b1;
        for (int k = 0; k < AREA_LEN; k++) ram[k] = 16'(k + 1);
        repeat (3) step();
        chk("reset.outputs",
            int'({o_done, o_error, om_err_code, o_ram_rd, om_ram_addr, o_tx_valid, om_tx_data}), 0);
        rst = 1'b0;
        repeat (2) step();

        // 1: nominal burst with ready high, plus timing
        begin_access(130, 0); finish_access(200); model(130);
        check_access("t1");
        chk("t1.csum", (beats.size() == 9) ? beats[8] : -1, 16'h0034);
        chk("t1.first_valid_latency", first_valid - c0, 4);
        gaps = 0;
        for (int i = 1; i < beat_cyc.size() && i < BURST_LEN; i++)
            if (beat_cyc[i] - beat_cyc[i-1] != 3) gaps++;
        chk("t1.word_spacing_errors", gaps, 0);

        // 2: last legal burst, then one past it
        begin_access(392, 0); finish_access(200); model(392); check_access("t2a");
        begin_access(393, 0); finish_access(200); model(393); check_access("t2b");

        // 3: outside the area on both sides
        begin_access(100, 0); finish_access(200); model(100); check_access("t3a");
        begin_access(400, 0); finish_access(200); model(400); check_access("t3b");

        // 4: TX timeout, then ready rising on the last allowed stalled cycle
        begin_access(130, 2); finish_access(3000);
        chk("t4a.error", err_hi, 1);
        chk("t4a.done", done_hi, 0);
        chk("t4a.code", int'(om_err_code), 3);
        chk("t4a.latency", err_at - first_valid, TIMEOUT);
        chk("t4a.valid_at_error", int'(valid_at_err), 0);
        chk("t4a.nbeats", beats.size(), 0);
        begin_access(130, 3); finish_access(3000); model(130); check_access("t4b");

        // 5: start re-pulsed mid-burst is ignored
        begin_access(130, 0);
        while (beats.size() < 3 && cyc - c0 < 200) step();
        i_start = 1'b1; im_base_addr = 10'd200;
        finish_access(200); model(130); check_access("t5");

        // 6: reset during beat 4 aborts silently, next access is clean
        begin_access(130, 0);
        while (beats.size() < 4 && cyc - c0 < 200) step();
        rst = 1'b1;
        step();
        chk("t6.rst_outputs",
            int'({o_done, o_error, om_err_code, o_ram_rd, om_ram_addr, o_tx_valid, om_tx_data}), 0);
        rst = 1'b0;
        repeat (20) step();
        chk("t6.no_pulse_after_rst", done_hi + err_hi, 0);
        begin_access(130, 0); finish_access(200); model(130); check_access("t6b");

        // Random RAM contents, addresses and ready pattern
        for (int k = 0; k < AREA_LEN; k++) ram[k] = 16'($urandom);
        for (int n = 0; n < 20; n++) begin
            r = int'($urandom_range(0, 3));
            case (r)
                0:       a = int'($urandom_range(0, 1023));
                3:       a = int'($urandom_range(380, 402));
                default: a = int'($urandom_range(AREA_BASE, AREA_BASE + AREA_LEN - BURST_LEN));
            endcase
            begin_access(a, 1); finish_access(2000); model(a);
            check_access($sformatf("rnd%0d_addr%0d", n, a));
            repeat (int'($urandom_range(0, 3))) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
